// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one combinational FP32 adder among NUM_REQ requesters.
// Latency: operands accepted in cycle T, result valid in T+2; one operation in flight at a time.
// Backpressure: req_ready only in IDLE; rsp_valid/rsp_data are held until rsp_ready of the granted requester.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    per-requester operand handshake (req_ready is at most one-hot)
//   req_a/req_b            packed operands, requester i at [i*DW +: DW]
//   rsp_valid/rsp_ready    one-hot result handshake towards the granted requester
//   rsp_data               shared sum, zero outside RESP
//   busy                   high while an operation is in EXEC or RESP
//   grant_id               index of the current or last granted requester
//
// adder: combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with denormals, signed zeros, Inf and NaN handling.

module adder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Res
);
  logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, rnd_up;
  logic [31:0] big, sml;
  logic [9:0]  e_big, e_sml, e_diff, e_n, e_fld, sh;
  logic [23:0] m_big, m_sml;
  logic [53:0] sh_full;
  logic [26:0] big_al, sml_al, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [30:0] mag;

  always_comb begin
    a_nan   = (&A[30:23]) & (|A[22:0]);
    b_nan   = (&B[30:23]) & (|B[22:0]);
    a_inf   = (&A[30:23]) & ~(|A[22:0]);
    b_inf   = (&B[30:23]) & ~(|B[22:0]);
    // Order by magnitude so the subtraction below never goes negative.
    swap    = (B[30:0] > A[30:0]);
    big     = swap ? B : A;
    sml     = swap ? A : B;
    eff_sub = A[31] ^ B[31];
    // Denormals use exponent 1 with no hidden bit.
    e_big   = (big[30:23] == 8'd0) ? 10'd1 : {2'b00, big[30:23]};
    e_sml   = (sml[30:23] == 8'd0) ? 10'd1 : {2'b00, sml[30:23]};
    m_big   = {|big[30:23], big[22:0]};
    m_sml   = {|sml[30:23], sml[22:0]};
    e_diff  = e_big - e_sml;
    // Align the smaller operand; everything shifted past the round bit folds into sticky.
    sh_full = {m_sml, 30'd0} >> ((e_diff > 10'd31) ? 10'd31 : e_diff);
    sml_al  = sh_full[53:27] | {26'd0, |sh_full[26:0]};
    big_al  = {m_big, 3'b000};
    sum     = eff_sub ? ({1'b0, big_al} - {1'b0, sml_al})
                      : ({1'b0, big_al} + {1'b0, sml_al});
    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e_n  = e_big + 10'd1;
      sh   = 10'd0;
    end else begin
      // Left shift stops at exponent 1, leaving a denormal result.
      sh   = ({5'd0, lz} > (e_big - 10'd1)) ? (e_big - 10'd1) : {5'd0, lz};
      norm = sum[26:0] << sh;
      e_n  = e_big - sh;
    end
    e_fld  = norm[26] ? e_n : 10'd0;
    rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
    // Rounding carry ripples naturally into the exponent field (denormal->normal, max->Inf).
    mag    = {e_fld[7:0], norm[25:3]} + {30'd0, rnd_up};
    if (a_nan)                        Res = A | 32'h0040_0000;
    else if (b_nan)                   Res = B | 32'h0040_0000;
    else if (a_inf & b_inf & eff_sub) Res = 32'h7FC0_0000;
    else if (a_inf)                   Res = A;
    else if (b_inf)                   Res = B;
    else if (sum == 28'd0)            Res = {~eff_sub & A[31], 31'd0};
    else if (e_fld >= 10'd255)        Res = {big[31], 8'hFF, 23'd0};
    else                              Res = {big[31], mag};
  end
endmodule

module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 32,
  localparam int GW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_a,
  input  logic [NUM_REQ*DW-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [DW-1:0]         rsp_data,
  output logic                  busy,
  output logic [GW-1:0]         grant_id
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [GW:0]   NR_W = (GW+1)'(NUM_REQ);
  localparam logic [GW-1:0] LAST = GW'(NUM_REQ - 1);

  state_e               state_q;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d, grant_id_q;
  logic [DW-1:0]        op_a_q, op_b_q, res_q, add_res, sel_a, sel_b;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic                 busy_q;
  logic                 gnt_vld;
  logic [GW-1:0]        gnt_idx;
  logic [GW:0]          scan;

  adder u_add (
    .A   (op_a_q),
    .B   (op_b_q),
    .Res (add_res)
  );

  // Scan from rr_ptr upward with wrap; iterating downward lets the nearest hit win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (scan >= NR_W) scan = scan - NR_W;
      if (req_valid[scan[GW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[GW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_a    = req_a[int'(gnt_idx)*DW +: DW];
  assign sel_b    = req_b[int'(gnt_idx)*DW +: DW];
  assign rr_ptr_d = (grant_id_q == LAST) ? '0 : grant_id_q + GW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            op_a_q     <= sel_a;
            op_b_q     <= sel_b;
            grant_id_q <= gnt_idx;
            busy_q     <= 1'b1;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          res_q       <= add_res;
          rsp_valid_q <= NUM_REQ'(1) << grant_id_q;
          state_q     <= RESP;
        end
        RESP: begin
          // Only the granted requester's rsp_ready completes the response.
          if (rsp_ready[grant_id_q]) begin
            res_q       <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = res_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
module tb_fp_add_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*DW-1:0]  req_a, req_b;
  logic [DW-1:0]     rsp_data;
  logic              busy;
  logic [1:0]        grant_id;

  fp_add_arbiter #(.NUM_REQ(NR), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          mptr;
  bit          va [NR];
  logic [31:0] ra [NR];
  logic [31:0] rb [NR];
  logic [31:0] rs [NR];

  // Special-value operand table: a, b, IEEE sum.
  localparam logic [31:0] SP_A [6] = '{32'h3F000000, 32'h3F800000, 32'h7F800000,
                                       32'h3F800000, 32'h00000001, 32'h7F7FFFFF};
  localparam logic [31:0] SP_B [6] = '{32'h3E800000, 32'h33800000, 32'h3F800000,
                                       32'hBF800000, 32'h00000001, 32'h7F7FFFFF};
  localparam logic [31:0] SP_S [6] = '{32'h3F400000, 32'h3F800000, 32'h7F800000,
                                       32'h00000000, 32'h00000002, 32'h7F800000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact integer -> FP32 encoding (operands stay below 2^21 in magnitude).
  function automatic logic [31:0] i2f(input int v);
    logic        s;
    logic [31:0] m;
    int          p;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = 32'(s ? -v : v);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return {s, 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  function automatic int rnd();
    return int'($urandom_range(2097150, 0)) - 1048575;
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    ra[i] = i2f(a);
    rb[i] = i2f(b);
    rs[i] = i2f(a + b);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]       = va[i];
      req_a[i*DW +: DW]  = ra[i];
      req_b[i*DW +: DW]  = rb[i];
    end
  endtask

  // Round-robin: first valid requester at or after the pointer.
  function automatic int pick();
    for (int k = 0; k < NR; k++) if (va[(mptr + k) % NR]) return (mptr + k) % NR;
    return -1;
  endfunction

  // Starts in an IDLE cycle just after a rising edge; returns likewise.
  task automatic serve(input int hold, input bit again, input int exp_g);
    int          g;
    logic [31:0] exp_sum;
    drive();
    g = pick();
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), (g < 0) ? 64'(0) : 64'(1 << g));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("idle_rsp_data", 64'(rsp_data), 64'(0));
    @(posedge clk); #1;
    if (g < 0) return;
    exp_sum = rs[g];
    va[g] = again;
    if (again) set_op(g, rnd(), rnd());
    rsp_ready[g] = (hold == 0);
    drive();
    @(negedge clk);
    chk("exec_req_ready", 64'(req_ready), 64'(0));
    chk("exec_busy", 64'(busy), 64'(1));
    chk("exec_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp_valid", 64'(rsp_valid), 64'(1 << g));
    chk("resp_data", 64'(rsp_data), 64'(exp_sum));
    chk("resp_grant", 64'(grant_id), 64'(g));
    chk("resp_req_ready", 64'(req_ready), 64'(0));
    if (exp_g >= 0) chk("grant_order", 64'(grant_id), 64'(exp_g));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == hold - 1) rsp_ready[g] = 1'b1;
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'(1 << g));
      chk("hold_data", 64'(rsp_data), 64'(exp_sum));
      chk("hold_req_ready", 64'(req_ready), 64'(0));
      chk("hold_busy", 64'(busy), 64'(1));
    end
    @(posedge clk); #1;
    mptr = (g + 1) % NR;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) va[i] = 1'b0;
    drive();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    mptr = 0;
  endtask

  initial begin
    rsp_ready = '1;
    for (int i = 0; i < NR; i++) begin
      ra[i] = '0; rb[i] = '0; rs[i] = '0; va[i] = 1'b0;
    end
    do_reset();

    // Single request, then a signed-operand request on requester 1.
    ra[0] = 32'h41200000; rb[0] = 32'h41700000; rs[0] = 32'h41C80000; va[0] = 1'b1;
    serve(0, 1'b0, 0);
    ra[1] = 32'hC2500000; rb[1] = 32'h41700000; rs[1] = 32'hC2140000; va[1] = 1'b1;
    serve(0, 1'b0, 1);

    // All requesters continuously valid: grants 0,1,2,3,0 back to back.
    do_reset();
    for (int i = 0; i < NR; i++) begin set_op(i, rnd(), rnd()); va[i] = 1'b1; end
    for (int k = 0; k < 5; k++) serve(0, 1'b1, k % NR);
    for (int i = 0; i < NR; i++) va[i] = 1'b0;

    // Fairness after serving requester 1 alone.
    do_reset();
    set_op(1, rnd(), rnd()); va[1] = 1'b1;
    serve(0, 1'b0, 1);
    set_op(0, rnd(), rnd()); va[0] = 1'b1;
    set_op(2, rnd(), rnd()); va[2] = 1'b1;
    serve(0, 1'b0, 2);
    serve(0, 1'b0, 0);

    // Response backpressure on requester 0 while requester 3 waits.
    do_reset();
    set_op(0, rnd(), rnd()); va[0] = 1'b1;
    set_op(3, rnd(), rnd()); va[3] = 1'b1;
    serve(5, 1'b0, 0);
    serve(0, 1'b0, 3);

    // Reset while requester 3 is in EXEC; pointer sits at 3 beforehand.
    set_op(2, rnd(), rnd()); va[2] = 1'b1;
    serve(0, 1'b0, 2);
    set_op(3, rnd(), rnd()); va[3] = 1'b1;
    drive();
    @(negedge clk);
    chk("mid_accept", 64'(req_ready), 64'(4'b1000));
    @(posedge clk); #1;
    va[3] = 1'b0; rst = 1'b1; drive();
    @(negedge clk);
    chk("mid_exec_busy", 64'(busy), 64'(1));
    chk("mid_exec_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_grant_id", 64'(grant_id), 64'(0));
    chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    mptr = 0;
    ra[0] = 32'h00000000; rb[0] = 32'h80000000; rs[0] = 32'h00000000; va[0] = 1'b1;
    set_op(3, rnd(), rnd()); va[3] = 1'b1;
    serve(0, 1'b0, 0);
    serve(0, 1'b0, 3);

    // Special values pass through the shared adder unchanged by the arbiter.
    for (int j = 0; j < 6; j++) begin
      ra[j % NR] = SP_A[j]; rb[j % NR] = SP_B[j]; rs[j % NR] = SP_S[j]; va[j % NR] = 1'b1;
      serve(0, 1'b0, j % NR);
    end

    // Random contention with random response stalls.
    for (int it = 0; it < 30; it++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (!va[i] && $urandom_range(1, 0) == 1) begin
          va[i] = 1'b1;
          set_op(i, rnd(), rnd());
        end
        any = any | va[i];
      end
      if (!any) begin va[it % NR] = 1'b1; set_op(it % NR, rnd(), rnd()); end
      serve(int'($urandom_range(2, 0)), 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
